interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 157 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: latches int_req edges, saves PC and flags on the
// stack, vectors to the ISR, and restores both on RTI.
module interrupt_sequencer #(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] VECTOR_ADDR = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            int_req,
    input  logic            instr_boundary,
    input  logic            rti,
    input  logic [PC_W-1:0] pc_cur,
    input  logic [2:0]      flags_cur,
    input  logic [PC_W-1:0] pop_data,
    input  logic            pop_valid,
    output logic            stall,
    output logic            push_en,
    output logic            pop_en,
    output logic [PC_W-1:0] push_data,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_value,
    output logic            flags_load,
    output logic [2:0]      flags_value,
    output logic            in_isr,
    output logic            int_ack
);

    typedef enum logic [3:0] {
        IDLE,
        STALL,
        PUSH_PC,
        PUSH_FLG,
        VECTOR,
        ISR,
        POP_FLG,
        WAIT_FLG,
        POP_PC,
        WAIT_PC
    } seqState_t;

    seqState_t       stateReg, stateNext;
    logic            pendingReg;
    logic            intReqPrevReg;
    logic [PC_W-1:0] pcSaveReg;
    logic [2:0]      flagsSaveReg;
    logic            intReqClean;
    logic            intReqEdge;
    logic            accept;

    // An X on int_req must never look like a request.
    assign intReqClean = (int_req === 1'b1);
    assign intReqEdge  = intReqClean & ~intReqPrevReg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg      <= IDLE;
            pendingReg    <= 1'b0;
            intReqPrevReg <= 1'b0;
            pcSaveReg     <= '0;
            flagsSaveReg  <= '0;
        end else begin
            stateReg      <= stateNext;
            intReqPrevReg <= intReqClean;
            // A fresh edge in the acceptance cycle is a new request and survives the clear.
            pendingReg    <= (pendingReg & ~accept) | intReqEdge;
            if (accept) begin
                pcSaveReg    <= pc_cur;
                flagsSaveReg <= flags_cur;
            end
        end
    end

    always_comb begin
        stateNext   = stateReg;
        accept      = 1'b0;
        stall       = 1'b0;
        push_en     = 1'b0;
        pop_en      = 1'b0;
        push_data   = '0;
        pc_load     = 1'b0;
        pc_value    = '0;
        flags_load  = 1'b0;
        flags_value = 3'b000;
        in_isr      = 1'b0;
        int_ack     = 1'b0;

        case (stateReg)
            IDLE: begin
                if (pendingReg && instr_boundary) begin
                    accept    = 1'b1;
                    int_ack   = 1'b1;
                    stateNext = STALL;
                end
            end
            STALL: begin
                stall     = 1'b1;
                stateNext = PUSH_PC;
            end
            PUSH_PC: begin
                stall     = 1'b1;
                push_en   = 1'b1;
                push_data = pcSaveReg;
                stateNext = PUSH_FLG;
            end
            PUSH_FLG: begin
                stall     = 1'b1;
                push_en   = 1'b1;
                push_data = {{(PC_W-3){1'b0}}, flagsSaveReg};
                stateNext = VECTOR;
            end
            VECTOR: begin
                stall     = 1'b1;
                pc_load   = 1'b1;
                pc_value  = VECTOR_ADDR;
                stateNext = ISR;
            end
            ISR: begin
                in_isr = 1'b1;
                if (rti) begin
                    stateNext = POP_FLG;
                end
            end
            POP_FLG: begin
                stall     = 1'b1;
                in_isr    = 1'b1;
                pop_en    = 1'b1;
                stateNext = WAIT_FLG;
            end
            WAIT_FLG: begin
                stall  = 1'b1;
                in_isr = 1'b1;
                if (pop_valid) begin
                    flags_load  = 1'b1;
                    flags_value = pop_data[2:0];
                    stateNext   = POP_PC;
                end
            end
            POP_PC: begin
                stall     = 1'b1;
                in_isr    = 1'b1;
                pop_en    = 1'b1;
                stateNext = WAIT_PC;
            end
            WAIT_PC: begin
                stall  = 1'b1;
                in_isr = 1'b1;
                if (pop_valid) begin
                    pc_load   = 1'b1;
                    pc_value  = pop_data;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: expected strobes are queued as stimulus
// is driven and matched in order as the DUT raises them; a small stack model answers pops.
module tb_interrupt_sequencer;

    localparam int PC_W = 16;
    localparam logic [3:0] EV_ACK  = 4'd1;
    localparam logic [3:0] EV_PUSH = 4'd2;
    localparam logic [3:0] EV_POP  = 4'd3;
    localparam logic [3:0] EV_PC   = 4'd4;
    localparam logic [3:0] EV_FLG  = 4'd5;

    logic            clk;
    logic            reset;
    logic            int_req;
    logic            instr_boundary;
    logic            rti;
    logic [PC_W-1:0] pc_cur;
    logic [2:0]      flags_cur;
    logic [PC_W-1:0] pop_data;
    logic            pop_valid;
    logic            stall;
    logic            push_en;
    logic            pop_en;
    logic [PC_W-1:0] push_data;
    logic            pc_load;
    logic [PC_W-1:0] pc_value;
    logic            flags_load;
    logic [2:0]      flags_value;
    logic            in_isr;
    logic            int_ack;

    int              testsRun;
    int              testsFailed;
    logic [31:0]     expQ[$];
    logic [PC_W-1:0] stackQ[$];
    bit              monEn;

    interrupt_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .int_req        (int_req),
        .instr_boundary (instr_boundary),
        .rti            (rti),
        .pc_cur         (pc_cur),
        .flags_cur      (flags_cur),
        .pop_data       (pop_data),
        .pop_valid      (pop_valid),
        .stall          (stall),
        .push_en        (push_en),
        .pop_en         (pop_en),
        .push_data      (push_data),
        .pc_load        (pc_load),
        .pc_value       (pc_value),
        .flags_load     (flags_load),
        .flags_value    (flags_value),
        .in_isr         (in_isr),
        .int_ack        (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] kind, input logic [15:0] data);
        return {12'h000, kind, data};
    endfunction

    task automatic sbCheck(input logic [31:0] obs);
        logic [31:0] exp;
        if (expQ.size() == 0) begin
            checkVal("unexpected_strobe", obs, 32'h0);
        end else begin
            exp = expQ.pop_front();
            checkVal("strobe", obs, exp);
            $display("[TB] event kind=%0d data=%h expected kind=%0d data=%h",
                     obs[19:16], obs[15:0], exp[19:16], exp[15:0]);
        end
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            checkVal("push_pop_excl", {31'b0, push_en & pop_en}, 32'h0);
            checkVal("load_excl", {31'b0, pc_load & flags_load}, 32'h0);
            if (int_ack)    sbCheck(ev(EV_ACK, 16'h0));
            if (push_en)    sbCheck(ev(EV_PUSH, push_data));
            if (pop_en)     sbCheck(ev(EV_POP, 16'h0));
            if (pc_load)    sbCheck(ev(EV_PC, pc_value));
            if (flags_load) sbCheck(ev(EV_FLG, {13'b0, flags_value}));
        end
    end

    // Stack model: pop data returned with pop_valid one cycle after pop_en.
    initial begin
        bit              doPop;
        logic [PC_W-1:0] popVal;
        pop_valid = 1'b0;
        pop_data  = '0;
        forever begin
            @(negedge clk);
            doPop  = (pop_en === 1'b1);
            popVal = 16'hDEAD;
            if (push_en === 1'b1) stackQ.push_back(push_data);
            if (doPop && stackQ.size() > 0) popVal = stackQ.pop_back();
            @(posedge clk);
            #1;
            pop_valid = doPop;
            pop_data  = popVal;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enterIsr(input logic [PC_W-1:0] pc, input logic [2:0] flags, input int hold);
        bit found;
        int n;
        pc_cur         = pc;
        flags_cur      = flags;
        instr_boundary = (hold == 0);
        expQ.push_back(ev(EV_ACK, 16'h0));
        expQ.push_back(ev(EV_PUSH, pc));
        expQ.push_back(ev(EV_PUSH, {13'b0, flags}));
        expQ.push_back(ev(EV_PC, 16'h0000));
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkVal("hold_no_ack", {31'b0, int_ack}, 32'h0);
            tick();
        end
        instr_boundary = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (int_ack) found = 1;
        end
        checkVal("ack_seen", {31'b0, found}, 32'h1);
        if (found) begin
            tick();
            pc_cur    = ~pc;
            flags_cur = ~flags;
            n = 0;
            found = 0;
            for (int i = 0; i < 10 && !found; i++) begin
                @(negedge clk);
                n++;
                if (pc_load) found = 1;
            end
            checkVal("entry_latency", n, 4);
            tick();
            @(negedge clk);
            checkVal("in_isr_entry", {31'b0, in_isr}, 32'h1);
            checkVal("stall_in_isr", {31'b0, stall}, 32'h0);
            tick();
        end
    endtask

    task automatic exitIsr(input logic [PC_W-1:0] pcRet, input logic [2:0] flagsRet, input bit alsoIrq);
        bit found;
        expQ.push_back(ev(EV_POP, 16'h0));
        expQ.push_back(ev(EV_FLG, {13'b0, flagsRet}));
        expQ.push_back(ev(EV_POP, 16'h0));
        expQ.push_back(ev(EV_PC, pcRet));
        pc_cur         = pcRet;
        flags_cur      = flagsRet;
        instr_boundary = 1'b1;
        if (alsoIrq) begin
            expQ.push_back(ev(EV_ACK, 16'h0));
            expQ.push_back(ev(EV_PUSH, pcRet));
            expQ.push_back(ev(EV_PUSH, {13'b0, flagsRet}));
            expQ.push_back(ev(EV_PC, 16'h0000));
            int_req = 1'b1;
        end
        rti = 1'b1;
        tick();
        rti     = 1'b0;
        int_req = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pc_load) found = 1;
        end
        checkVal("restore_seen", {31'b0, found}, 32'h1);
        tick();
        @(negedge clk);
        checkVal("in_isr_after_ret", {31'b0, in_isr}, 32'h0);
        checkVal("stall_after_ret", {31'b0, stall}, 32'h0);
        checkVal("reentry_ack", {31'b0, int_ack}, {31'b0, alsoIrq});
        if (alsoIrq) begin
            found = 0;
            for (int i = 0; i < 10 && !found; i++) begin
                @(negedge clk);
                if (in_isr) found = 1;
            end
            checkVal("reentry_isr", {31'b0, found}, 32'h1);
        end
        tick();
    endtask

    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        monEn          = 0;
        reset          = 1'b0;
        int_req        = 1'b0;
        instr_boundary = 1'b1;
        rti            = 1'b0;
        pc_cur         = '0;
        flags_cur      = '0;

        // Reset, with an int_req edge that must not survive it
        tick();
        monEn = 1;
        int_req = 1'b1;
        @(negedge clk);
        checkVal("reset_outs", {25'b0, stall, push_en, pop_en, pc_load, flags_load, in_isr, int_ack}, 32'h0);
        tick();
        int_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("no_ack_after_reset", {31'b0, int_ack}, 32'h0);
            tick();
        end

        // Basic entry and return
        enterIsr(16'h0005, 3'b101, 0);
        exitIsr(16'h0005, 3'b101, 0);

        // Boundary hold
        enterIsr(16'h0100, 3'b011, 3);
        exitIsr(16'h0100, 3'b011, 0);

        // Interrupt arriving together with RTI: exit then re-entry
        enterIsr(16'h0200, 3'b110, 0);
        exitIsr(16'h0200, 3'b110, 1);
        exitIsr(16'h0200, 3'b110, 0);

        // Stray RTI in IDLE
        rti = 1'b1;
        tick();
        rti = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("stray_rti", {28'b0, pop_en, pc_load, flags_load, stall}, 32'h0);
            tick();
        end

        // Reset while in PUSH_FLG with another request pending
        pc_cur    = 16'h1234;
        flags_cur = 3'b010;
        expQ.push_back(ev(EV_ACK, 16'h0));
        expQ.push_back(ev(EV_PUSH, 16'h1234));
        expQ.push_back(ev(EV_PUSH, 16'h0002));
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        @(negedge clk);
        checkVal("rst_seq_ack", {31'b0, int_ack}, 32'h1);
        tick();
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkVal("rst_mid_strobes", {25'b0, stall, push_en, pop_en, pc_load, flags_load, in_isr, int_ack}, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal("rst_pending_cleared", {29'b0, int_ack, push_en, pc_load}, 32'h0);
            tick();
        end

        checkVal("queue_empty", expQ.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
